// File: rtl/aes_pkg.sv
// AES tables, state encoding and GF(2^8) helpers shared by the
// inverse-cipher datapath.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXPAND,
    INIT,
    ROUND,
    FINAL
  } state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Padded to 16 so any 4-bit counter value indexes safely
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [3:0] m
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]],
            SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {
      gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
      gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
      gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
      gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)
    };
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; i_final drops InvMixColumns
// for the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rkey,
  input  logic         i_final,
  output logic [127:0] o_state
);

  logic [127:0] w_sb;
  logic [127:0] w_ak;
  logic [127:0] w_mc;

  // Byte k = r + 4c; row r rotates right by r positions
  always_comb begin
    w_sb = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sb[127-8*(r+4*c) -: 8] =
          INV_SBOX[i_state[127-8*(r+4*((c-r+4)%4)) -: 8]];
      end
    end
  end

  assign w_ak = w_sb ^ i_rkey;

  assign w_mc = {inv_mix_col(w_ak[127:96]),
                 inv_mix_col(w_ak[95:64]),
                 inv_mix_col(w_ak[63:32]),
                 inv_mix_col(w_ak[31:0])};

  assign o_state = i_final ? w_ak : w_mc;

endmodule

// File: rtl/aes128_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Define AES_DEC_KEY_CACHE_EN to reuse round key 10 for a repeated key.
module aes128_inv_cipher
  import aes_pkg::*;
(
  input  logic         CLK,
  input  logic         rst,
  input  logic         Valid,
  input  logic [127:0] Key,
  input  logic [127:0] Cypher_txt,
  output logic [127:0] Plain_txt,
  output logic         Busy,
  output logic         Done
);

  state_e       r_state, w_state_nx;
  logic [127:0] r_key, w_key_nx;
  logic [127:0] r_st, w_st_nx;
  logic [127:0] r_pt, w_pt_nx;
  logic [3:0]   r_cnt, w_cnt_nx;
  logic         r_busy, w_busy_nx;
  logic         r_done, w_done_nx;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] r_ckey, w_ckey_nx;
  logic [127:0] r_crk, w_crk_nx;
  logic         r_cv, w_cv_nx;
`endif

  logic [3:0]   w_rc_idx;
  logic [31:0]  w_rc;
  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [31:0]  w_f0, w_f1, w_f2, w_f3;
  logic [31:0]  w_b0, w_b1, w_b2, w_b3;
  logic [31:0]  w_t;
  logic [127:0] w_fwd, w_inv, w_rnd;
  logic         w_final;

  assign {w_k0, w_k1, w_k2, w_k3} = r_key;

  // Expansion uses Rcon[i]; walking back to key r uses Rcon[r+1]
  assign w_rc_idx = (r_state == EXPAND) ? r_cnt : r_cnt + 4'd1;
  assign w_rc     = {RCON[w_rc_idx], 24'h0};

  assign w_t   = sub_word({w_k3[23:0], w_k3[31:24]}) ^ w_rc;
  assign w_f0  = w_k0 ^ w_t;
  assign w_f1  = w_k1 ^ w_f0;
  assign w_f2  = w_k2 ^ w_f1;
  assign w_f3  = w_k3 ^ w_f2;
  assign w_fwd = {w_f0, w_f1, w_f2, w_f3};

  assign w_b3  = w_k3 ^ w_k2;
  assign w_b2  = w_k2 ^ w_k1;
  assign w_b1  = w_k1 ^ w_k0;
  assign w_b0  = w_k0 ^ sub_word({w_b3[23:0], w_b3[31:24]}) ^ w_rc;
  assign w_inv = {w_b0, w_b1, w_b2, w_b3};

  assign w_final = (r_state == FINAL);

  aes_inv_round u_round (
    .i_state (r_st),
    .i_rkey  (w_inv),
    .i_final (w_final),
    .o_state (w_rnd)
  );

  always_comb begin
    w_state_nx = r_state;
    w_key_nx   = r_key;
    w_st_nx    = r_st;
    w_pt_nx    = r_pt;
    w_cnt_nx   = r_cnt;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
    w_ckey_nx  = r_ckey;
    w_crk_nx   = r_crk;
    w_cv_nx    = r_cv;
`endif
    case (r_state)
      IDLE: begin
        if (Valid) begin
          w_key_nx   = Key;
          w_st_nx    = Cypher_txt;
          w_busy_nx  = 1'b1;
          w_cnt_nx   = 4'd1;
          w_state_nx = EXPAND;
`ifdef AES_DEC_KEY_CACHE_EN
          if (r_cv && (Key == r_ckey)) begin
            w_key_nx   = r_crk;
            w_state_nx = INIT;
          end else begin
            w_ckey_nx = Key;
            w_cv_nx   = 1'b0;
          end
`endif
        end
      end
      EXPAND: begin
        w_key_nx = w_fwd;
        w_cnt_nx = r_cnt + 4'd1;
        if (r_cnt == 4'd10) begin
          w_state_nx = INIT;
`ifdef AES_DEC_KEY_CACHE_EN
          w_crk_nx = w_fwd;
          w_cv_nx  = 1'b1;
`endif
        end
      end
      INIT: begin
        w_st_nx    = r_st ^ r_key;
        w_cnt_nx   = 4'd9;
        w_state_nx = ROUND;
      end
      ROUND: begin
        w_key_nx = w_inv;
        w_st_nx  = w_rnd;
        w_cnt_nx = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nx = FINAL;
      end
      FINAL: begin
        w_key_nx   = w_inv;
        w_pt_nx    = w_rnd;
        w_done_nx  = 1'b1;
        w_busy_nx  = 1'b0;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_st    <= '0;
      r_pt    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      r_ckey  <= '0;
      r_crk   <= '0;
      r_cv    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_key   <= w_key_nx;
      r_st    <= w_st_nx;
      r_pt    <= w_pt_nx;
      r_cnt   <= w_cnt_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
`ifdef AES_DEC_KEY_CACHE_EN
      r_ckey  <= w_ckey_nx;
      r_crk   <= w_crk_nx;
      r_cv    <= w_cv_nx;
`endif
    end
  end

  assign Plain_txt = r_pt;
  assign Busy      = r_busy;
  assign Done      = r_done;

endmodule

// File: tb/tb_aes128_inv_cipher.sv
// Bench for aes128_inv_cipher: FIPS vectors plus random blocks encrypted
// by an independent forward-cipher model built from GF(2^8) arithmetic.
module tb_aes128_inv_cipher;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         rst;
  logic         Valid;
  logic [127:0] Key;
  logic [127:0] Cypher_txt;
  logic [127:0] Plain_txt;
  logic         Busy;
  logic         Done;

  int n_run  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  aes128_inv_cipher dut (
    .CLK        (CLK),
    .rst        (rst),
    .Valid      (Valid),
    .Key        (Key),
    .Cypher_txt (Cypher_txt),
    .Plain_txt  (Plain_txt),
    .Busy       (Busy),
    .Done       (Done)
  );

  typedef struct {
    string        nm;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat_nc;
    int           lat_c;
  } vec_t;

  logic [7:0]   m_sbox [256];
  bit           m_cv = 1'b0;
  logic [127:0] m_ckey = '0;

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // S-box from multiplicative inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] v;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      m_sbox[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] k,
                                           input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) begin
        w[i] = k[127-32*i -: 32];
      end else begin
        tmp = w[i-1];
        if (i % 4 == 0) begin
          tmp = {m_sbox[tmp[23:16]], m_sbox[tmp[15:8]],
                 m_sbox[tmp[7:0]], m_sbox[tmp[31:24]]} ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end
        w[i] = w[i-4] ^ tmp;
      end
    end
    for (int b = 0; b < 16; b++)
      s[b] = p[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int b = 0; b < 16; b++)
        t[b] = m_sbox[s[(b%4) + 4*(((b/4) + (b%4)) % 4)]];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int b = 0; b < 16; b++)
        s[b] = t[b] ^ w[4*rd + b/4][31-8*(b%4) -: 8];
    end
    o = '0;
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = s[b];
    return o;
  endfunction

  function automatic int model_lat(input logic [127:0] k);
    return (CACHE_EN && m_cv && (k == m_ckey)) ? 11 : 21;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end while (!Done && lat < 60);
  endtask

  task automatic do_req(input string nm, input logic [127:0] k,
                        input logic [127:0] c, input logic [127:0] p,
                        input int el);
    int lat;
    @(negedge CLK);
    Valid = 1'b1; Key = k; Cypher_txt = c;
    @(posedge CLK);
    @(negedge CLK);
    Valid = 1'b0; Key = rnd128(); Cypher_txt = rnd128();
    check({nm, " busy"}, 128'(Busy), 128'(1));
    wait_done(lat);
    check({nm, " latency"}, 128'(lat), 128'(el));
    check({nm, " plain"}, Plain_txt, p);
    m_ckey = k; m_cv = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check({nm, " done pulse"}, 128'(Done), 128'(0));
    check({nm, " hold"}, Plain_txt, p);
  endtask

  // Valid stays high through the busy period and the Done cycle
  task automatic b2b(input string nm, input logic [127:0] k1,
                     input logic [127:0] p1, input logic [127:0] k2,
                     input logic [127:0] p2);
    int lat, el;
    el = model_lat(k1);
    @(negedge CLK);
    Valid = 1'b1; Key = k1; Cypher_txt = encrypt(k1, p1);
    @(posedge CLK);
    @(negedge CLK);
    Key = k2; Cypher_txt = encrypt(k2, p2);
    wait_done(lat);
    check({nm, " first latency"}, 128'(lat), 128'(el));
    check({nm, " first plain"}, Plain_txt, p1);
    m_ckey = k1; m_cv = 1'b1;
    el = model_lat(k2);
    @(posedge CLK);
    @(negedge CLK);
    Valid = 1'b0;
    check({nm, " second busy"}, 128'(Busy), 128'(1));
    wait_done(lat);
    check({nm, " second latency"}, 128'(lat), 128'(el));
    check({nm, " second plain"}, Plain_txt, p2);
    m_ckey = k2; m_cv = 1'b1;
  endtask

  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    vec_t         vecs [5];
    logic [127:0] k, p, c;
    int           n_done, d_edge, el;

    vecs[0] = '{"appB_1", KB, CB, PB, 21, 21};
    vecs[1] = '{"c1_1",   KC, CC, PC, 21, 21};
    vecs[2] = '{"appB_2", KB, CB, PB, 21, 21};
    vecs[3] = '{"c1_2",   KC, CC, PC, 21, 21};
    vecs[4] = '{"c1_rep", KC, CC, PC, 21, 11};

    build_sbox();
    rst = 1'b1; Valid = 1'b0; Key = '0; Cypher_txt = '0;
    repeat (3) @(negedge CLK);
    check("reset busy", 128'(Busy), 128'(0));
    check("reset done", 128'(Done), 128'(0));
    check("reset plain", Plain_txt, 128'(0));
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      do_req(vecs[i].nm, vecs[i].key, vecs[i].ct, vecs[i].pt,
             CACHE_EN ? vecs[i].lat_c : vecs[i].lat_nc);

    k = rnd128();
    for (int i = 0; i < 8; i++) begin
      if (i % 3 != 2) k = rnd128();
      p = rnd128();
      c = encrypt(k, p);
      do_req($sformatf("rand%0d", i), k, c, p, model_lat(k));
    end

    // Valid pulses at edges 5 and 15 of a running request
    k = rnd128(); p = rnd128(); c = encrypt(k, p);
    el = model_lat(k);
    @(negedge CLK);
    Valid = 1'b1; Key = k; Cypher_txt = c;
    @(posedge CLK);
    @(negedge CLK);
    Key = KC; Cypher_txt = CC;
    n_done = 0; d_edge = 0;
    for (int e = 1; e <= 30; e++) begin
      Valid = (e == 5 || e == 15);
      @(posedge CLK);
      @(negedge CLK);
      if (Done) begin
        n_done++;
        if (n_done == 1) d_edge = e;
      end
    end
    Valid = 1'b0;
    check("ignore done count", 128'(n_done), 128'(1));
    check("ignore latency", 128'(d_edge), 128'(el));
    check("ignore plain", Plain_txt, p);
    m_ckey = k; m_cv = 1'b1;

    // Abort at edge 12, then a fresh request must expand fully
    k = rnd128(); p = rnd128(); c = encrypt(k, p);
    @(negedge CLK);
    Valid = 1'b1; Key = k; Cypher_txt = c;
    @(posedge CLK);
    @(negedge CLK);
    Valid = 1'b0;
    repeat (12) @(posedge CLK);
    #1 rst = 1'b1;
    #1;
    check("abort busy", 128'(Busy), 128'(0));
    check("abort done", 128'(Done), 128'(0));
    check("abort plain", Plain_txt, 128'(0));
    m_cv = 1'b0;
    @(negedge CLK);
    rst = 1'b0;
    do_req("after_rst", KC, CC, PC, 21);

    b2b("b2b_same", KB, PB, KB, rnd128());
    b2b("b2b_diff", KB, rnd128(), KC, PC);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
